// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Combinational interface only; no latency of its own.
// Flow control: imem_req is held with a stable imem_addr until imem_ack is seen.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, requests imem, and loads the IF/ID register.
// Latency: zero-wait memory lands in IF/ID on the edge ending the request cycle.
// Backpressure: stall holds IF/ID and parks one returning word in a skid entry.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   fetch_stage_if.master        imem,
   output logic [31:0]          IF_ID_PC,
   output logic [31:0]          IF_ID_Inst,
   output logic                 IF_ID_Valid
);

   typedef enum logic {S_REQ = 1'b0, S_DROP = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic        sb_valid_q, sb_valid_d;
   logic [31:0] sb_pc_q, sb_pc_d;
   logic [31:0] sb_inst_q, sb_inst_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_valid_q, if_valid_d;

   logic        req;
   logic        fire;
   logic        drop_done;

   // Request is suppressed while the skid entry is occupied; a dropped request
   // must still be carried to completion at its original address.
   assign req       = !rst && ((state_q == S_REQ && !sb_valid_q) || state_q == S_DROP);
   assign fire      = req && imem.imem_ack && (state_q == S_REQ);
   assign drop_done = req && imem.imem_ack && (state_q == S_DROP);

   assign imem.imem_req  = req;
   assign imem.imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

   assign IF_ID_PC    = if_pc_q;
   assign IF_ID_Inst  = if_inst_q;
   assign IF_ID_Valid = if_valid_q;

   // Next-state: redirect beats stall beats normal flow; everything holds by default.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      sb_valid_d  = sb_valid_q;
      sb_pc_d     = sb_pc_q;
      sb_inst_d   = sb_inst_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;
      if_valid_d  = if_valid_q;

      // The ack for a dropped request retires it regardless of what else happens;
      // its data never reaches IF/ID.
      if (drop_done) begin
         state_d = S_REQ;
      end

      if (redirect) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         if_valid_d = 1'b0;
         if_inst_d  = NOP_INST;
         sb_valid_d = 1'b0;
         // An un-acked request cannot be withdrawn, so remember where it went
         // and swallow its response later. A same-cycle fire is simply discarded.
         if (state_q == S_REQ && req && !imem.imem_ack) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
         end
      end else if (stall) begin
         if (fire) begin
            sb_valid_d = 1'b1;
            sb_pc_d    = pc_q;
            sb_inst_d  = imem.imem_rdata;
            pc_d       = pc_q + 32'd4;
         end
      end else begin
         if (sb_valid_q) begin
            // Skid drains first; req is low this cycle so no fire can collide.
            if_pc_d    = sb_pc_q;
            if_inst_d  = sb_inst_q;
            if_valid_d = 1'b1;
            sb_valid_d = 1'b0;
         end else if (fire) begin
            if_pc_d    = pc_q;
            if_inst_d  = imem.imem_rdata;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
         end else begin
            if_inst_d  = NOP_INST;
            if_valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         drop_addr_q <= 32'd0;
         sb_valid_q  <= 1'b0;
         sb_pc_q     <= 32'd0;
         sb_inst_q   <= 32'd0;
         if_pc_q     <= 32'd0;
         if_inst_q   <= NOP_INST;
         if_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         sb_valid_q  <= sb_valid_d;
         sb_pc_q     <= sb_pc_d;
         sb_inst_q   <= sb_inst_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
         if_valid_q  <= if_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem model with programmable ack latency, scoreboard of
// expected IF/ID instructions, and scenario tasks for stall, redirect and reset.
// Inputs change 1ns after posedge; outputs are sampled then or at negedge.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] IF_ID_PC;
   logic [31:0] IF_ID_Inst;
   logic        IF_ID_Valid;

   fetch_stage_if imem_bus ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem       (imem_bus),
      .IF_ID_PC   (IF_ID_PC),
      .IF_ID_Inst (IF_ID_Inst),
      .IF_ID_Valid(IF_ID_Valid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   // Memory content is a scramble of the address so each word is distinct.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // imem model: lat = cycles from request to ack, counted inclusively (1 = zero-wait).
   logic mem_en = 1'b0;
   int   lat    = 1;
   int   wcnt   = 0;

   assign imem_bus.imem_ack   = mem_en && imem_bus.imem_req && (wcnt >= lat - 1);
   assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

   always @(posedge clk) begin
      if (rst || !imem_bus.imem_req || imem_bus.imem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   // IF/ID is written on any edge out of reset that is not stalled (redirect loads a bubble).
   logic ld_q = 1'b0;
   always @(posedge clk) ld_q <= !rst && (!stall || redirect);

   // Scoreboard: every freshly loaded valid instruction must be the next expected one.
   always @(negedge clk) begin
      if (ld_q && IF_ID_Valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got PC=%h inst=%h, required no valid instruction", IF_ID_PC, IF_ID_Inst);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (IF_ID_PC !== e || IF_ID_Inst !== mem_word(e)) begin
               errors++;
               $display("FAIL sb_order: got PC=%h inst=%h, required PC=%h inst=%h", IF_ID_PC, IF_ID_Inst, e, mem_word(e));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      mem_en = 1'b1; lat = 1;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_low: got %b, required 0", imem_bus.imem_req); end
      cyc(); cyc();
      checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", IF_ID_Valid); end
      checks++; if (IF_ID_Inst !== NOP) begin errors++; $display("FAIL rst_inst: got %h, required %h", IF_ID_Inst, NOP); end
      checks++; if (IF_ID_PC !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h, required 0", IF_ID_PC); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      rst = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'(i * 4)) begin
            errors++;
            $display("FAIL seq_addr: got req=%b addr=%h, required req=1 addr=%h", imem_bus.imem_req, imem_bus.imem_addr, 32'(i * 4));
         end
         cyc();
      end
      mem_en = 1'b0;
      cyc();
      checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL seq_bubble: got valid=%b, required 0", IF_ID_Valid); end
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h20) begin errors++; $display("FAIL seq_hold_addr: got req=%b addr=%h, required 1/00000020", imem_bus.imem_req, imem_bus.imem_addr); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drained: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) exp_q.push_back(32'h20 + 32'(i * 4));
      mem_en = 1'b1;
      cyc(); cyc();
      stall = 1'b1;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h28) begin errors++; $display("FAIL stall_fetch_addr: got req=%b addr=%h, required 1/00000028", imem_bus.imem_req, imem_bus.imem_addr); end
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (IF_ID_PC !== 32'h24 || IF_ID_Valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got PC=%h valid=%b req=%b, required 00000024/1/0", i, IF_ID_PC, IF_ID_Valid, imem_bus.imem_req);
         end
      end
      stall = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_drain_req: got %b, required 0", imem_bus.imem_req); end
      cyc();
      checks++; if (IF_ID_PC !== 32'h28 || IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL stall_skid_out: got PC=%h valid=%b, required 00000028/1", IF_ID_PC, IF_ID_Valid); end
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h2C) begin errors++; $display("FAIL stall_resume_addr: got req=%b addr=%h, required 1/0000002c", imem_bus.imem_req, imem_bus.imem_addr); end
      cyc();
      checks++; if (IF_ID_PC !== 32'h2C) begin errors++; $display("FAIL stall_next: got PC=%h, required 0000002c", IF_ID_PC); end
      cyc();
      mem_en = 1'b0;
      cyc();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drained: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect_skid();
      mem_en = 1'b1; stall = 1'b1;
      cyc();
      mem_en = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rskid_full: got req=%b, required 0", imem_bus.imem_req); end
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      cyc();
      redirect = 1'b0; stall = 1'b0; redirect_pc = 32'd0;
      #1;
      checks++; if (IF_ID_Valid !== 1'b0 || IF_ID_Inst !== NOP || IF_ID_PC !== 32'h30) begin errors++; $display("FAIL rskid_bubble: got PC=%h inst=%h valid=%b, required 00000030/%h/0", IF_ID_PC, IF_ID_Inst, IF_ID_Valid, NOP); end
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rskid_target: got req=%b addr=%h, required 1/00000100", imem_bus.imem_req, imem_bus.imem_addr); end
      exp_q.push_back(32'h100);
      mem_en = 1'b1;
      cyc();
      mem_en = 1'b0;
      cyc();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rskid_drained: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect_fire();
      mem_en = 1'b1; lat = 1; redirect = 1'b1; redirect_pc = 32'h40;
      #1;
      checks++; if (imem_bus.imem_ack !== 1'b1 || imem_bus.imem_addr !== 32'h104) begin errors++; $display("FAIL rfire_setup: got ack=%b addr=%h, required 1/00000104", imem_bus.imem_ack, imem_bus.imem_addr); end
      cyc();
      redirect = 1'b0; lat = 3;
      #1;
      checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL rfire_discard: got valid=%b, required 0", IF_ID_Valid); end
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rfire_next_addr: got req=%b addr=%h, required 1/00000040", imem_bus.imem_req, imem_bus.imem_addr); end
   endtask

   task automatic test_latency_redirect();
      redirect = 1'b1; redirect_pc = 32'h200;
      cyc();
      redirect = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h40 || imem_bus.imem_ack !== 1'b0) begin errors++; $display("FAIL lat_hold1: got req=%b addr=%h ack=%b, required 1/00000040/0", imem_bus.imem_req, imem_bus.imem_addr, imem_bus.imem_ack); end
      cyc();
      checks++; if (imem_bus.imem_addr !== 32'h40 || imem_bus.imem_ack !== 1'b1) begin errors++; $display("FAIL lat_hold2: got addr=%h ack=%b, required 00000040/1", imem_bus.imem_addr, imem_bus.imem_ack); end
      cyc();
      checks++; if (IF_ID_Valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h200) begin errors++; $display("FAIL lat_after_drop: got valid=%b req=%b addr=%h, required 0/1/00000200", IF_ID_Valid, imem_bus.imem_req, imem_bus.imem_addr); end
      exp_q.push_back(32'h200);
      cyc(); cyc();
      checks++; if (imem_bus.imem_ack !== 1'b1) begin errors++; $display("FAIL lat_ack3: got ack=%b, required 1", imem_bus.imem_ack); end
      cyc();
      checks++; if (IF_ID_PC !== 32'h200 || IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL lat_target: got PC=%h valid=%b, required 00000200/1", IF_ID_PC, IF_ID_Valid); end
      mem_en = 1'b0; lat = 1;
   endtask

   task automatic test_reset_midflight();
      stall = 1'b1;
      cyc();
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h204) begin errors++; $display("FAIL rmid_outstanding: got req=%b addr=%h, required 1/00000204", imem_bus.imem_req, imem_bus.imem_addr); end
      rst = 1'b1;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_low: got %b, required 0", imem_bus.imem_req); end
      cyc();
      checks++; if (IF_ID_Valid !== 1'b0 || IF_ID_Inst !== NOP || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmid_cleared: got valid=%b inst=%h req=%b, required 0/%h/0", IF_ID_Valid, IF_ID_Inst, imem_bus.imem_req, NOP); end
      rst = 1'b0; stall = 1'b0; mem_en = 1'b1;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_restart: got req=%b addr=%h, required 1/00000000", imem_bus.imem_req, imem_bus.imem_addr); end
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      cyc(); cyc();
      mem_en = 1'b0;
      cyc();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drained: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      cyc();
      redirect = 1'b0; redirect_pc = 32'd0; mem_en = 1'b1;
      #1;
      checks++; if (imem_bus.imem_addr !== 32'h8) begin errors++; $display("FAIL wrap_drop_addr: got %h, required 00000008", imem_bus.imem_addr); end
      cyc();
      checks++; if (IF_ID_Valid !== 1'b0 || imem_bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got valid=%b addr=%h, required 0/fffffffc", IF_ID_Valid, imem_bus.imem_addr); end
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      cyc(); cyc();
      mem_en = 1'b0;
      #1;
      checks++; if (imem_bus.imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_pc: got %h, required 00000004", imem_bus.imem_addr); end
      cyc();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drained: got %0d left, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_skid();
      test_redirect_fire();
      test_latency_redirect();
      test_reset_midflight();
      test_wrap();
      cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 32-bit RISC-V core. It owns the PC and issues requests to instruction memory over a req/ack handshake. It delivers {PC, instruction, valid} to the decode stage and honours the load-use `stall` from the hazard detection unit and branch/jump redirects from EX. A one-entry skid buffer captures an instruction that returns while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, encoding driven on IF_ID_Inst for a bubble (addi x0,x0,0).

Ports:
clk  in  1  core clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
stall  in  1  from hazard detection unit; 1 = hold IF/ID and PC advance.
redirect  in  1  branch taken / jump / flush resolved in EX.
redirect_pc  in  32  target PC, valid when redirect=1.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address; word-aligned.
imem_ack  in  1  memory response; completes the transaction when imem_req=1 in the same cycle.
imem_rdata  in  32  instruction; valid when imem_ack=1.
IF_ID_PC  out  32  PC of the instruction in IF/ID.
IF_ID_Inst  out  32  instruction in IF/ID (NOP_INST when invalid).
IF_ID_Valid  out  1  1 = IF/ID holds a real instruction.

Behaviour:
- Reset (rst=1 at posedge):
  - pc<=RESET_PC, state<=REQ, sb_valid<=0.
  - IF_ID_PC<=0, IF_ID_Inst<=NOP_INST, IF_ID_Valid<=0.
  - imem_req forced 0 while rst=1.
  - Reset mid-transaction abandons the request; memory is required to drop it.
- States:
  - REQ: normal fetch at pc.
  - DROP: a request is outstanding whose data must be discarded; addr held in drop_addr.
- imem_req = !rst && ((state==REQ && !sb_valid) || state==DROP).
- imem_addr = pc in REQ, drop_addr in DROP.
- Request rule: addr stays stable while req=1 and ack=0. Zero-wait memory (ack in the same cycle as req) is supported. ack with req=0 is ignored.
- fire = imem_req && imem_ack && state==REQ.
- Priority per posedge: rst > redirect > stall > normal.
- Redirect (redirect=1):
  - pc<=redirect_pc.
  - IF/ID<=bubble (Valid 0, Inst NOP_INST, PC unchanged).
  - sb_valid<=0.
  - If state==REQ, imem_req=1 and ack=0: drop_addr<=pc, state<=DROP.
  - If fire: the returned data is discarded, state stays REQ.
  - In DROP: pc updated, remains DROP (drop_addr unchanged).
  - Redirect overrides stall.
- Stall (stall=1, no redirect):
  - IF/ID holds all three outputs.
  - On fire: sb<={pc, imem_rdata}, sb_valid<=1, pc<=pc+4.
  - With sb_valid=1 no request is issued.
- Normal (stall=0, no redirect):
  - If sb_valid: IF/ID<={sb_pc, sb_inst, 1}, sb_valid<=0. No fire is possible this cycle because req=0.
  - Else if fire: IF/ID<={pc, imem_rdata, 1}, pc<=pc+4.
  - Else: IF/ID<=bubble.
- DROP: on imem_req&&imem_ack the data is discarded, state<=REQ. No IF/ID load from the discarded data; a bubble is inserted unless stalled.
- Latency: with zero-wait memory, an instruction reaches IF/ID on the posedge ending its request cycle. Throughput is 1 instruction/cycle.
- PC arithmetic: 32-bit modulo; pc+4 wraps 32'hFFFF_FFFC -> 0. redirect_pc[1:0] is ignored (forced 00).
- Simultaneous stall deassert and skid drain: the skid is used first; fetch resumes the following cycle.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory returning addr-based words -> imem_addr 0,4,8… on consecutive cycles; IF_ID_PC 0,4,8 one per cycle, Valid=1 from first posedge after fetch.
- Stall for 3 cycles while fetching PC=0x10 -> IF/ID holds PC 0x0C. 0x10 is captured in skid; imem_req=0 for the remaining stall cycles. On release IF_ID_PC=0x10, then 0x14 next cycle, no loss or duplication.
- Redirect to 0x100 with stall=1 and skid full -> next cycle IF_ID_Valid=0, Inst=0x00000013, skid cleared; next fetch addr=0x100.
- Memory with 3-cycle ack latency; redirect to 0x200 in cycle 1 of fetch at 0x40 -> imem_addr stays 0x40 until ack, data discarded, no Valid for 0x40. Next request addr=0x200.
- Redirect and fire in the same cycle (zero-wait) -> fetched word discarded, state REQ, next addr = redirect_pc.
- rst asserted while a request is outstanding and stall=1 -> next cycle IF_ID_Valid=0, pc=RESET_PC, skid empty; imem_req=0 while rst=1.
